// File: rtl/ervp_axi_region_remapper_pkg.sv
// Shared widths, APB register map and region configuration type for the
// AXI region remapper.
package ervp_axi_region_remapper_pkg;
    localparam int BW_AXI_ALEN   = 4;
    localparam int BW_AXI_ASIZE  = 3;
    localparam int BW_AXI_ABURST = 2;
    localparam int BW_AXI_BRESP  = 2;
    localparam int BW_AXI_RRESP  = 2;

    localparam int         REG_STRIDE    = 16;
    localparam logic [3:0] OFF_BASE      = 4'h0;
    localparam logic [3:0] OFF_MASK      = 4'h4;
    localparam logic [3:0] OFF_TARGET    = 4'h8;
    localparam logic [3:0] OFF_CTRL      = 4'hC;
    localparam logic [8:0] OFF_BLOCK_CNT = 9'h100;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_WPROT = 1;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
        logic [31:0] target;
        logic        en;
        logic        wprot;
    } region_cfg_t;
endpackage

// File: rtl/ervp_axi_region_remapper_if.sv
// AXI3 (with WID) five-channel bundle. valid/ready: a beat transfers on any
// rising clk edge where both are high; the source holds payload stable until then.
interface ervp_axi_region_remapper_if
    import ervp_axi_region_remapper_pkg::*;
#(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_AXI_TID = 1
);
    logic [BW_AXI_TID-1:0]    awid;
    logic [BW_ADDR-1:0]       awaddr;
    logic [BW_AXI_ALEN-1:0]   awlen;
    logic [BW_AXI_ASIZE-1:0]  awsize;
    logic [BW_AXI_ABURST-1:0] awburst;
    logic                     awvalid;
    logic                     awready;
    logic [BW_AXI_TID-1:0]    wid;
    logic [BW_DATA-1:0]       wdata;
    logic [BW_DATA/8-1:0]     wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;
    logic [BW_AXI_TID-1:0]    bid;
    logic [BW_AXI_BRESP-1:0]  bresp;
    logic                     bvalid;
    logic                     bready;
    logic [BW_AXI_TID-1:0]    arid;
    logic [BW_ADDR-1:0]       araddr;
    logic [BW_AXI_ALEN-1:0]   arlen;
    logic [BW_AXI_ASIZE-1:0]  arsize;
    logic [BW_AXI_ABURST-1:0] arburst;
    logic                     arvalid;
    logic                     arready;
    logic [BW_AXI_TID-1:0]    rid;
    logic [BW_DATA-1:0]       rdata;
    logic [BW_AXI_RRESP-1:0]  rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );
    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/ervp_region_remap_lookup.sv
// Combinational window match: the lowest enabled matching region supplies the
// target bits above its mask; no match leaves the address untouched.
module ervp_region_remap_lookup
    import ervp_axi_region_remapper_pkg::*;
#(
    parameter int BW_ADDR    = 32,
    parameter int NUM_REGION = 8
) (
    input  region_cfg_t        cfg [NUM_REGION],
    input  logic [BW_ADDR-1:0] addr,
    output logic [BW_ADDR-1:0] remap_addr,
    output logic               hit,
    output logic               wprot
);
    logic [BW_ADDR-1:0] mask;

    // Walk from the top down so the lowest index is the last to assign.
    always_comb begin
        remap_addr = addr;
        hit        = 1'b0;
        wprot      = 1'b0;
        mask       = '0;
        for (int i = NUM_REGION - 1; i >= 0; i--) begin
            mask = BW_ADDR'(cfg[i].mask);
            if (cfg[i].en && ((addr & ~mask) == (BW_ADDR'(cfg[i].base) & ~mask))) begin
                hit        = 1'b1;
                wprot      = cfg[i].wprot;
                remap_addr = (BW_ADDR'(cfg[i].target) & ~mask) | (addr & mask);
            end
        end
    end
endmodule

// File: rtl/ervp_sync_fifo.sv
// Small synchronous FIFO with an extra wrap bit on each pointer; depth is a power of 2.
module ervp_sync_fifo #(
    parameter int BW_DATA = 1,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               push,
    input  logic [BW_DATA-1:0] push_data,
    output logic               full,
    input  logic               pop,
    output logic [BW_DATA-1:0] pop_data,
    output logic               empty
);
    localparam int BW_PTR = $clog2(DEPTH);

    logic [BW_DATA-1:0] mem [DEPTH];
    logic [BW_PTR:0]    wptr;
    logic [BW_PTR:0]    rptr;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[BW_PTR] != rptr[BW_PTR]) && (wptr[BW_PTR-1:0] == rptr[BW_PTR-1:0]);
    assign pop_data = mem[rptr[BW_PTR-1:0]];

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[BW_PTR-1:0]] <= push_data;
    end
endmodule

// File: rtl/ervp_axi_region_remapper.sv
// AXI address remapping shim: APB-programmed windows redirect AR/AW addresses
// through 1-cycle slices; write-protected bursts have their strobes zeroed.
module ervp_axi_region_remapper
    import ervp_axi_region_remapper_pkg::*;
#(
    parameter int BW_ADDR        = 32,
    parameter int BW_DATA        = 32,
    parameter int BW_AXI_TID     = 1,
    parameter int NUM_REGION     = 8,
    parameter int WR_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rstnn,
    ervp_axi_region_remapper_if.slave  rx,
    ervp_axi_region_remapper_if.master sx,
    input  logic [BW_ADDR-1:0]  rpaddr,
    input  logic                rpwrite,
    input  logic                rpsel,
    input  logic                rpenable,
    input  logic [31:0]         rpwdata,
    output logic [31:0]         rprdata,
    output logic                rpready,
    output logic                rpslverr
);
    region_cfg_t cfg [NUM_REGION];
    logic [31:0] block_cnt;

    logic [8:0]  offset;
    logic        is_region, is_cnt, reg_wr;
    logic [31:0] rd_data;

    assign offset    = rpaddr[8:0];
    assign is_region = (offset[1:0] == 2'b00) && (int'(offset) < NUM_REGION * REG_STRIDE);
    assign is_cnt    = (offset == OFF_BLOCK_CNT);
    assign reg_wr    = rpsel && rpenable && rpwrite;
    assign rpready   = 1'b1;
    assign rpslverr  = rpsel && rpenable && !(is_region || is_cnt);

    always_comb begin
        rd_data = '0;
        if (is_cnt) rd_data = block_cnt;
        for (int i = 0; i < NUM_REGION; i++) begin
            if (is_region && offset[7:4] == 4'(i)) begin
                case (offset[3:0])
                    OFF_BASE:   rd_data = cfg[i].base;
                    OFF_MASK:   rd_data = cfg[i].mask;
                    OFF_TARGET: rd_data = cfg[i].target;
                    OFF_CTRL: begin
                        rd_data[CTRL_EN]    = cfg[i].en;
                        rd_data[CTRL_WPROT] = cfg[i].wprot;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read data is latched in the setup phase so it is stable through the access phase.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            rprdata <= '0;
        end else if (rpsel && !rpenable && !rpwrite) begin
            rprdata <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int i = 0; i < NUM_REGION; i++) cfg[i] <= '0;
        end else if (reg_wr && is_region) begin
            for (int i = 0; i < NUM_REGION; i++) begin
                if (offset[7:4] == 4'(i)) begin
                    case (offset[3:0])
                        OFF_BASE:   cfg[i].base   <= rpwdata;
                        OFF_MASK:   cfg[i].mask   <= rpwdata;
                        OFF_TARGET: cfg[i].target <= rpwdata;
                        OFF_CTRL: begin
                            cfg[i].en    <= rpwdata[CTRL_EN];
                            cfg[i].wprot <= rpwdata[CTRL_WPROT];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [BW_ADDR-1:0] ar_remap, aw_remap;
    logic               ar_hit, ar_wprot, aw_hit, aw_wprot;

    ervp_region_remap_lookup #(.BW_ADDR(BW_ADDR), .NUM_REGION(NUM_REGION)) u_ar_lookup (
        .cfg(cfg), .addr(rx.araddr), .remap_addr(ar_remap), .hit(ar_hit), .wprot(ar_wprot)
    );
    ervp_region_remap_lookup #(.BW_ADDR(BW_ADDR), .NUM_REGION(NUM_REGION)) u_aw_lookup (
        .cfg(cfg), .addr(rx.awaddr), .remap_addr(aw_remap), .hit(aw_hit), .wprot(aw_wprot)
    );

    logic ar_v, ar_acc, aw_v, aw_acc;
    logic fifo_full, fifo_empty, head_flag, w_pop;

    assign rx.arready = !ar_v || sx.arready;
    assign ar_acc     = rx.arvalid && rx.arready;
    assign sx.arvalid = ar_v;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            ar_v <= 1'b0;
            {sx.arid, sx.araddr, sx.arlen, sx.arsize, sx.arburst} <= '0;
        end else if (ar_acc) begin
            ar_v <= 1'b1;
            {sx.arid, sx.araddr, sx.arlen, sx.arsize, sx.arburst} <=
                {rx.arid, ar_remap, rx.arlen, rx.arsize, rx.arburst};
        end else if (sx.arready) begin
            ar_v <= 1'b0;
        end
    end

    // AW also waits for a free flag slot so every accepted burst owns its W-strobe decision.
    assign rx.awready = (!aw_v || sx.awready) && !fifo_full;
    assign aw_acc     = rx.awvalid && rx.awready;
    assign sx.awvalid = aw_v;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            aw_v <= 1'b0;
            {sx.awid, sx.awaddr, sx.awlen, sx.awsize, sx.awburst} <= '0;
        end else if (aw_acc) begin
            aw_v <= 1'b1;
            {sx.awid, sx.awaddr, sx.awlen, sx.awsize, sx.awburst} <=
                {rx.awid, aw_remap, rx.awlen, rx.awsize, rx.awburst};
        end else if (sx.awready) begin
            aw_v <= 1'b0;
        end
    end

    ervp_sync_fifo #(.BW_DATA(1), .DEPTH(WR_OUTSTANDING)) u_flag_fifo (
        .clk(clk), .rstnn(rstnn),
        .push(aw_acc), .push_data(aw_wprot), .full(fifo_full),
        .pop(w_pop), .pop_data(head_flag), .empty(fifo_empty)
    );

    assign sx.wvalid = rx.wvalid && !fifo_empty;
    assign rx.wready = sx.wready && !fifo_empty;
    assign sx.wid    = rx.wid;
    assign sx.wdata  = rx.wdata;
    assign sx.wlast  = rx.wlast;
    assign sx.wstrb  = head_flag ? '0 : rx.wstrb;
    assign w_pop     = rx.wvalid && rx.wready && rx.wlast;

    // An APB clear in the same cycle as a blocked-burst pop takes precedence.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            block_cnt <= '0;
        end else if (reg_wr && is_cnt) begin
            block_cnt <= '0;
        end else if (w_pop && head_flag && block_cnt != '1) begin
            block_cnt <= block_cnt + 32'd1;
        end
    end

    assign rx.bid    = sx.bid;
    assign rx.bresp  = sx.bresp;
    assign rx.bvalid = sx.bvalid;
    assign sx.bready = rx.bready;
    assign rx.rid    = sx.rid;
    assign rx.rdata  = sx.rdata;
    assign rx.rresp  = sx.rresp;
    assign rx.rlast  = sx.rlast;
    assign rx.rvalid = sx.rvalid;
    assign sx.rready = rx.rready;

    logic unused_bits;
    assign unused_bits = &{1'b0, ar_hit, ar_wprot, aw_hit, rpaddr};
endmodule

// File: tb/tb_ervp_axi_region_remapper.sv
// Directed bench for the AXI region remapper: AR/AW/W beats are checked against
// expected queues as they leave the downstream port.
module tb_ervp_axi_region_remapper;
    logic        clk;
    logic        rstnn;
    logic [31:0] rpaddr;
    logic        rpwrite, rpsel, rpenable;
    logic [31:0] rpwdata;
    logic [31:0] rprdata;
    logic        rpready, rpslverr;

    int n_cmp = 0;
    int n_err = 0;

    logic [35:0] exp_ar_q[$];
    logic [35:0] exp_aw_q[$];
    logic [35:0] exp_w_q[$];

    ervp_axi_region_remapper_if #(.BW_ADDR(32), .BW_DATA(32), .BW_AXI_TID(1)) rx ();
    ervp_axi_region_remapper_if #(.BW_ADDR(32), .BW_DATA(32), .BW_AXI_TID(1)) sx ();

    ervp_axi_region_remapper #(
        .BW_ADDR(32), .BW_DATA(32), .BW_AXI_TID(1), .NUM_REGION(8), .WR_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rstnn(rstnn), .rx(rx), .sx(sx),
        .rpaddr(rpaddr), .rpwrite(rpwrite), .rpsel(rpsel), .rpenable(rpenable),
        .rpwdata(rpwdata), .rprdata(rprdata), .rpready(rpready), .rpslverr(rpslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [35:0] ar_e, aw_e, w_e;
    always @(negedge clk) begin
        if (rstnn && sx.arvalid && sx.arready) begin
            check("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
            if (exp_ar_q.size() != 0) begin
                ar_e = exp_ar_q.pop_front();
                check("ar_len_addr", {sx.arlen, sx.araddr}, ar_e);
            end
        end
        if (rstnn && sx.awvalid && sx.awready) begin
            check("aw_expected", 64'(exp_aw_q.size() != 0), 64'd1);
            if (exp_aw_q.size() != 0) begin
                aw_e = exp_aw_q.pop_front();
                check("aw_len_addr", {sx.awlen, sx.awaddr}, aw_e);
            end
        end
        if (rstnn && sx.wvalid && sx.wready) begin
            check("w_expected", 64'(exp_w_q.size() != 0), 64'd1);
            if (exp_w_q.size() != 0) begin
                w_e = exp_w_q.pop_front();
                check("w_data_strb", {sx.wdata, sx.wstrb}, w_e);
            end
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        rpsel = 1'b1; rpwrite = 1'b1; rpenable = 1'b0; rpaddr = addr; rpwdata = data;
        @(posedge clk); #1 rpenable = 1'b1;
        @(posedge clk); #1 rpsel = 1'b0; rpenable = 1'b0; rpwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        rpsel = 1'b1; rpwrite = 1'b0; rpenable = 1'b0; rpaddr = addr;
        @(posedge clk); #1 rpenable = 1'b1;
        @(negedge clk); data = rprdata; err = rpslverr;
        @(posedge clk); #1 rpsel = 1'b0; rpenable = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] exp_addr, input bit track);
        logic ok; int n;
        rx.arid = 1'b0; rx.araddr = addr; rx.arlen = len; rx.arsize = 3'd2; rx.arburst = 2'd1;
        rx.arvalid = 1'b1;
        if (track) exp_ar_q.push_back({len, exp_addr});
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin @(negedge clk); ok = rx.arready; @(posedge clk); n++; end
        #1 rx.arvalid = 1'b0;
        check("ar_accept", 64'(ok), 64'd1);
        check("ar_latency", 64'(sx.arvalid), 64'd1);
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] exp_addr);
        logic ok; int n;
        rx.awid = 1'b0; rx.awaddr = addr; rx.awlen = len; rx.awsize = 3'd2; rx.awburst = 2'd1;
        rx.awvalid = 1'b1;
        exp_aw_q.push_back({len, exp_addr});
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin @(negedge clk); ok = rx.awready; @(posedge clk); n++; end
        #1 rx.awvalid = 1'b0;
        check("aw_accept", 64'(ok), 64'd1);
        check("aw_latency", 64'(sx.awvalid), 64'd1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input logic [3:0] exp_strb);
        logic ok; int n;
        rx.wid = 1'b0; rx.wdata = data; rx.wstrb = strb; rx.wlast = last; rx.wvalid = 1'b1;
        exp_w_q.push_back({data, exp_strb});
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin @(negedge clk); ok = rx.wready; @(posedge clk); n++; end
        #1 rx.wvalid = 1'b0; rx.wlast = 1'b0;
        check("w_accept", 64'(ok), 64'd1);
    endtask

    logic [31:0] rd;
    logic        err;

    initial begin
        rstnn = 1'b0;
        rpaddr = '0; rpwrite = 1'b0; rpsel = 1'b0; rpenable = 1'b0; rpwdata = '0;
        rx.awid = '0; rx.awaddr = '0; rx.awlen = '0; rx.awsize = '0; rx.awburst = '0; rx.awvalid = 1'b0;
        rx.wid = '0; rx.wdata = '0; rx.wstrb = '0; rx.wlast = 1'b0; rx.wvalid = 1'b0; rx.bready = 1'b0;
        rx.arid = '0; rx.araddr = '0; rx.arlen = '0; rx.arsize = '0; rx.arburst = '0; rx.arvalid = 1'b0;
        rx.rready = 1'b0;
        sx.awready = 1'b1; sx.wready = 1'b1; sx.arready = 1'b1;
        sx.bid = '0; sx.bresp = '0; sx.bvalid = 1'b0;
        sx.rid = '0; sx.rdata = '0; sx.rresp = '0; sx.rlast = 1'b0; sx.rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstnn = 1'b1;

        // Step 1: reset state and identity mapping
        check("rst_arvalid", 64'(sx.arvalid), 64'd0);
        check("rst_awvalid", 64'(sx.awvalid), 64'd0);
        rx.wvalid = 1'b1;
        #1 check("rst_fifo_empty_wvalid", 64'(sx.wvalid), 64'd0);
        rx.wvalid = 1'b0;
        check("rst_rprdata", 64'(rprdata), 64'd0);
        @(posedge clk); #1;
        send_ar(32'h8000_0040, 4'd0, 32'h8000_0040, 1'b1);
        apb_read(32'h100, rd, err);
        check("blk_cnt_reset", 64'(rd), 64'd0);
        check("blk_cnt_slverr", 64'(err), 64'd0);
        apb_read(32'h104, rd, err);
        check("undef_slverr", 64'(err), 64'd1);
        check("undef_rdata", 64'(rd), 64'd0);

        // Step 2: region 0 remap
        apb_write(32'h000, 32'h8000_0000);
        apb_write(32'h004, 32'h0000_FFFF);
        apb_write(32'h008, 32'h2000_0000);
        apb_write(32'h00C, 32'h0000_0001);
        apb_read(32'h008, rd, err);
        check("r0_target_rb", 64'(rd), 64'h2000_0000);
        apb_read(32'h00C, rd, err);
        check("r0_ctrl_rb", 64'(rd), 64'h1);
        send_aw(32'h8000_1234, 4'd0, 32'h2000_1234);
        send_w(32'hCAFE_0001, 4'hF, 1'b1, 4'hF);
        send_ar(32'h8001_0000, 4'd3, 32'h8001_0000, 1'b1);

        // Step 3: priority between overlapping regions
        apb_write(32'h000, 32'h9000_0000);
        apb_write(32'h030, 32'h9000_0000);
        apb_write(32'h034, 32'h0000_00FF);
        apb_write(32'h038, 32'h3000_0000);
        apb_write(32'h03C, 32'h0000_0001);
        send_ar(32'h9000_0010, 4'd1, 32'h2000_0010, 1'b1);
        apb_write(32'h00C, 32'h0000_0000);
        send_ar(32'h9000_0010, 4'd1, 32'h3000_0010, 1'b1);

        // Step 4: write-protected burst
        apb_write(32'h010, 32'hA000_0000);
        apb_write(32'h014, 32'h0000_0FFF);
        apb_write(32'h018, 32'hB000_0000);
        apb_write(32'h01C, 32'h0000_0003);
        send_aw(32'hA000_0100, 4'd3, 32'hB000_0100);
        for (int i = 0; i < 4; i++)
            send_w(32'h1111_0000 + 32'(i), 4'hF, 1'(i == 3), 4'h0);
        sx.bid = 1'b1; sx.bresp = 2'b10; sx.bvalid = 1'b1; rx.bready = 1'b1;
        sx.rid = 1'b1; sx.rdata = 32'h5A5A_1234; sx.rresp = 2'b01; sx.rlast = 1'b1;
        sx.rvalid = 1'b1; rx.rready = 1'b1;
        @(negedge clk);
        check("b_pass", {rx.bvalid, rx.bid, rx.bresp, sx.bready}, {1'b1, 1'b1, 2'b10, 1'b1});
        check("r_pass", {rx.rvalid, rx.rid, rx.rdata, rx.rresp, rx.rlast, sx.rready},
              {1'b1, 1'b1, 32'h5A5A_1234, 2'b01, 1'b1, 1'b1});
        @(posedge clk); #1;
        sx.bvalid = 1'b0; rx.bready = 1'b0; sx.rvalid = 1'b0; rx.rready = 1'b0;
        apb_read(32'h100, rd, err);
        check("blk_cnt_one", 64'(rd), 64'd1);
        apb_write(32'h100, 32'h0);
        apb_read(32'h100, rd, err);
        check("blk_cnt_cleared", 64'(rd), 64'd0);

        // Step 5: flag FIFO full backpressure on AW
        for (int i = 0; i < 4; i++)
            send_aw(32'h1000_0000 + 32'(i * 64), 4'd0, 32'h1000_0000 + 32'(i * 64));
        rx.awaddr = 32'h1000_0100; rx.awlen = 4'd0; rx.awvalid = 1'b1;
        exp_aw_q.push_back({4'd0, 32'h1000_0100});
        @(negedge clk); check("aw_blocked_full_0", 64'(rx.awready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); check("aw_blocked_full_1", 64'(rx.awready), 64'd0);
        @(posedge clk); #1;
        rx.wdata = 32'h2222_0000; rx.wstrb = 4'hF; rx.wlast = 1'b1; rx.wvalid = 1'b1;
        exp_w_q.push_back({32'h2222_0000, 4'hF});
        @(negedge clk);
        check("w_ready_when_full", 64'(rx.wready), 64'd1);
        check("aw_blocked_before_pop", 64'(rx.awready), 64'd0);
        @(posedge clk); #1 rx.wvalid = 1'b0; rx.wlast = 1'b0;
        @(negedge clk); check("aw_ready_after_pop", 64'(rx.awready), 64'd1);
        @(posedge clk); #1 rx.awvalid = 1'b0;
        check("aw_latency_after_pop", 64'(sx.awvalid), 64'd1);
        for (int i = 0; i < 4; i++)
            send_w(32'h3333_0000 + 32'(i), 4'hF, 1'b1, 4'hF);

        // Step 6: asynchronous reset with traffic in flight
        sx.arready = 1'b0;
        send_ar(32'h8000_0040, 4'd0, 32'h8000_0040, 1'b0);
        rx.araddr = 32'h8000_0080; rx.arvalid = 1'b1;
        send_aw(32'hA000_0000, 4'd0, 32'hB000_0000);
        sx.wready = 1'b0;
        rx.wdata = 32'h4444_0000; rx.wstrb = 4'hF; rx.wlast = 1'b1; rx.wvalid = 1'b1;
        @(negedge clk);
        check("pre_rst_arvalid", 64'(sx.arvalid), 64'd1);
        check("pre_rst_wvalid", 64'(sx.wvalid), 64'd1);
        #2 rstnn = 1'b0;
        #1;
        check("async_rst_arvalid", 64'(sx.arvalid), 64'd0);
        check("async_rst_wvalid", 64'(sx.wvalid), 64'd0);
        rx.arvalid = 1'b0;
        @(posedge clk); #1 rstnn = 1'b1;
        check("post_rst_fifo_empty", 64'(sx.wvalid), 64'd0);
        check("post_rst_arvalid", 64'(sx.arvalid), 64'd0);
        check("post_rst_rprdata", 64'(rprdata), 64'd0);
        rx.wvalid = 1'b0; rx.wlast = 1'b0;
        sx.wready = 1'b1; sx.arready = 1'b1;
        apb_read(32'h01C, rd, err);
        check("post_rst_r1_ctrl", 64'(rd), 64'd0);
        apb_read(32'h018, rd, err);
        check("post_rst_r1_target", 64'(rd), 64'd0);
        send_ar(32'hA000_0100, 4'd0, 32'hA000_0100, 1'b1);

        repeat (4) @(posedge clk);
        check("ar_q_drained", 64'(exp_ar_q.size()), 64'd0);
        check("aw_q_drained", 64'(exp_aw_q.size()), 64'd0);
        check("w_q_drained", 64'(exp_w_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
